note_sequencer: RTL and testbench

//  Schedules the note stream shown by the three-slot note display (past/current/future).

---
 rtl/note_pkg.sv | 16 +
 rtl/note_fifo.sv | 55 +++++
 rtl/note_sequencer.sv | 134 +++++++++++++
 tb/tb_note_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer: note width, rest code,
// sequencer state encoding and the pixel position that marks a frame start.
package note_pkg;

  localparam int NOTE_W = 6;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  localparam logic [10:0] FRAME_X0 = 11'd0;
  localparam logic [9:0]  FRAME_Y0 = 10'd0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous show-ahead FIFO for pending note codes; head is valid whenever
// the FIFO is not empty. DEPTH must be a power of two so pointers wrap freely.
module note_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (i_rst_n && !i_clear && w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/note_sequencer.sv
// Feeds the past/current/future note display, shifting slots only at frame start.
// Optional build macro NOTE_SEQ_DEDUP_EN drops accepted notes repeating the last code.
module note_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_FRAMES = 30,
  parameter int NOTE_W      = note_pkg::NOTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  input  logic [NOTE_W-1:0] in_note,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [NOTE_W-1:0] past,
  output logic [NOTE_W-1:0] current,
  output logic [NOTE_W-1:0] future,
  output logic              frame_tick,
  output logic              busy
);
  import note_pkg::*;

  localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_FRAMES - 1);

  state_t            r_state;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [NOTE_W-1:0] r_past;
  logic [NOTE_W-1:0] r_current;
  logic [NOTE_W-1:0] r_future;
  logic              r_at_q;
  logic              r_frame_tick;
  logic              r_flush_pend;

  logic              w_at;
  logic              w_full;
  logic              w_empty;
  logic [NOTE_W-1:0] w_head;
  logic              w_accept;
  logic              w_dup;
  logic              w_push;
  logic              w_pop;
  logic              w_flush_any;
  logic              w_shift;
  logic [NOTE_W-1:0] w_new_future;

  assign w_at     = (x == FRAME_X0) && (y == FRAME_Y0);
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;

`ifdef NOTE_SEQ_DEDUP_EN
  logic [NOTE_W-1:0] r_last;

  always_ff @(posedge clk) begin
    if (!reset || flush) r_last <= NOTE_REST;
    else if (w_accept)   r_last <= in_note;
  end

  assign w_dup = (in_note == r_last);
`else
  assign w_dup = 1'b0;
`endif

  assign w_push      = w_accept && !w_dup && !flush;
  assign w_flush_any = flush || r_flush_pend;
  assign w_shift     = r_frame_tick && !w_flush_any &&
                       (((r_state == IDLE) && !w_empty) ||
                        ((r_state == HOLD) && (r_hold_cnt == HC_LAST)));
  assign w_pop        = w_shift && !w_empty;
  assign w_new_future = w_empty ? NOTE_REST : w_head;

  note_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (NOTE_W)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_clear (flush),
    .i_push  (w_push),
    .i_data  (in_note),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_past       <= NOTE_REST;
      r_current    <= NOTE_REST;
      r_future     <= NOTE_REST;
      r_at_q       <= 1'b0;
      r_frame_tick <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_at_q       <= w_at;
      r_frame_tick <= w_at && !r_at_q;
      if (flush) r_flush_pend <= 1'b1;
      if (r_frame_tick) begin
        // A pending flush wins over any shift scheduled for this frame.
        if (w_flush_any) begin
          r_past       <= NOTE_REST;
          r_current    <= NOTE_REST;
          r_future     <= NOTE_REST;
          r_hold_cnt   <= '0;
          r_state      <= IDLE;
          r_flush_pend <= 1'b0;
        end else if (w_shift) begin
          r_past     <= r_current;
          r_current  <= r_future;
          r_future   <= w_new_future;
          r_hold_cnt <= '0;
          if ((r_current == NOTE_REST) && (r_future == NOTE_REST) &&
              (w_new_future == NOTE_REST) && w_empty)
            r_state <= IDLE;
          else
            r_state <= HOLD;
        end else if (r_state == HOLD) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  assign past       = r_past;
  assign current    = r_current;
  assign future     = r_future;
  assign frame_tick = r_frame_tick;
  assign busy       = (r_state == HOLD);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed and randomized bench for note_sequencer against a queue-based
// model of the display schedule; define NOTE_SEQ_DEDUP_EN to check dedup builds.
module tb_note_sequencer;

  localparam int FIFO_DEPTH  = 4;
  localparam int HOLD_FRAMES = 2;
  localparam int NOTE_W      = 6;
`ifdef NOTE_SEQ_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [10:0]       x = 11'd100;
  logic [9:0]        y = 10'd50;
  logic [NOTE_W-1:0] in_note = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic [NOTE_W-1:0] past, current, future;
  logic              frame_tick, busy;

  int checks = 0;
  int failures = 0;
  int ticks_seen = 0;

  // Model state: pending notes, the three visible slots, frames held so far.
  int q[$];
  int m_slot[3];
  int m_hold;
  int m_last;
  bit m_busy, m_pend, m_tick, m_at_q;

  note_sequencer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .HOLD_FRAMES (HOLD_FRAMES),
    .NOTE_W      (NOTE_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .in_note    (in_note),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .past       (past),
    .current    (current),
    .future     (future),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_slot = '{0, 0, 0};
    m_hold = 0;
    m_last = 0;
    m_busy = 0;
    m_pend = 0;
    m_tick = 0;
    m_at_q = 0;
  endfunction

  // Applies one clock edge worth of the display rules to the model.
  function automatic void model_edge();
    bit at, acc, dup, time_to_show, was_empty;
    int nf;
    if (!reset) begin
      model_reset();
      return;
    end
    at  = (x == 0) && (y == 0);
    acc = in_valid && (q.size() < FIFO_DEPTH);
    dup = DEDUP && (int'(in_note) == m_last);
    if (m_tick) begin
      time_to_show = m_busy ? (m_hold == HOLD_FRAMES - 1) : (q.size() > 0);
      if (flush || m_pend) begin
        m_slot = '{0, 0, 0};
        m_hold = 0;
        m_busy = 0;
        m_pend = 0;
      end else if (time_to_show) begin
        was_empty = (q.size() == 0);
        nf = was_empty ? 0 : q.pop_front();
        m_slot = '{m_slot[1], m_slot[2], nf};
        m_hold = 0;
        m_busy = !(m_slot[0] == 0 && m_slot[1] == 0 && m_slot[2] == 0 && was_empty);
      end else if (m_busy) begin
        m_hold++;
      end
    end else if (flush) begin
      m_pend = 1;
    end
    if (acc && !flush && !dup) q.push_back(int'(in_note));
    if (acc && !flush) m_last = int'(in_note);
    if (flush) begin
      q.delete();
      m_last = 0;
    end
    m_tick = at && !m_at_q;
    m_at_q = at;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    ticks_seen += int'(frame_tick);
    chk("past", past, m_slot[0]);
    chk("current", current, m_slot[1]);
    chk("future", future, m_slot[2]);
    chk("frame_tick", frame_tick, m_tick);
    chk("busy", busy, m_busy);
    chk("in_ready", in_ready, q.size() < FIFO_DEPTH);
  endtask

  task automatic push(int note);
    in_valid = 1'b1;
    in_note  = NOTE_W'(note);
    step();
    in_valid = 1'b0;
  endtask

  task automatic frame(int nz, int nr);
    for (int i = 0; i < nz; i++) begin
      x = '0;
      y = '0;
      step();
    end
    for (int i = 0; i < nr; i++) begin
      x = 11'($urandom_range(1, 1599));
      y = 10'($urandom_range(0, 1023));
      step();
    end
  endtask

  task automatic chk_slots(string tag, int p, int c, int f);
    chk({tag, "_past"}, past, p);
    chk({tag, "_current"}, current, c);
    chk({tag, "_future"}, future, f);
  endtask

  initial begin
    model_reset();

    // Reset state
    step();
    step();
    chk_slots("rst", 0, 0, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", frame_tick, 0);
    reset = 1'b1;
    step();

    // Scheduling with HOLD_FRAMES=2
    push(5);
    push(9);
    push(12);
    frame(1, 4);
    chk_slots("tick1", 0, 0, 5);
    chk("tick1_busy", busy, 1);
    frame(1, 4);
    frame(1, 4);
    chk_slots("tick3", 0, 5, 9);
    frame(1, 4);
    frame(1, 4);
    chk_slots("tick5", 5, 9, 12);
    frame(1, 4);
    frame(1, 4);
    chk_slots("tick7", 9, 12, 0);
    for (int i = 0; i < 4; i++) frame(1, 4);
    chk_slots("drain", 0, 0, 0);
    chk("drain_busy", busy, 0);

    // One tick for a long x=0,y=0 dwell
    ticks_seen = 0;
    frame(10, 4);
    chk("one_tick", ticks_seen, 1);

    // Fill with no ticks; extra offers are refused
    for (int n = 1; n <= 4; n++) push(n);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_note  = 6'd33;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    chk("full_hold_ready", in_ready, 0);

    // Flush in HOLD with two buffered
    frame(1, 4);
    frame(1, 4);
    frame(1, 4);
    chk_slots("pre_flush", 0, 1, 2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_note  = 6'd50;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_ready", in_ready, 1);
    chk("flush_busy_held", busy, 1);
    step();
    frame(1, 4);
    chk_slots("post_flush", 0, 0, 0);
    chk("post_flush_busy", busy, 0);
    frame(1, 4);
    chk("flush_drop", future, 0);

    // Repeated code handling
    push(7);
    push(7);
    push(8);
    frame(1, 4);
    chk("dup_t1", future, 7);
    frame(1, 4);
    frame(1, 4);
    chk("dup_t3", future, DEDUP ? 8 : 7);
    frame(1, 4);
    frame(1, 4);
    chk("dup_t5", future, DEDUP ? 0 : 8);
    for (int i = 0; i < 8; i++) frame(1, 3);

    // Randomized traffic with a mid-run reset
    for (int c = 0; c < 600; c++) begin
      reset    = !(c >= 300 && c < 302);
      in_valid = ($urandom_range(0, 1) == 1);
      in_note  = NOTE_W'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) begin
        x = '0;
        y = '0;
      end else begin
        x = 11'($urandom_range(0, 3));
        y = 10'($urandom_range(0, 2));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
